// File: rtl/adder_pkg.sv
// Shared definitions for the adder family (adder, subtractor, ALU).
package adder_pkg;

  // Widest instance the ripple-carry core is allowed to elaborate.
  localparam int ADDER_MAX_WIDTH = 64;

  // Two's-complement overflow: both operands share a sign and the result
  // sign differs from it.
  function automatic logic adder_overflow(input logic a_msb,
                                          input logic b_msb,
                                          input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_core_if.sv
// Operand/result bundle for adder_core. The master drives operands,
// and the slave (the adder) returns registered results.
interface adder_core_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Sum;
  logic             carry_out;
  logic             overflow;
  logic             out_valid;

  modport master (
    output in_valid, A, B,
    input  Sum, carry_out, overflow, out_valid
  );

  modport slave (
    input  in_valid, A, B,
    output Sum, carry_out, overflow, out_valid
  );
endinterface

// File: rtl/full_adder.sv
// One-bit full-adder cell, the building block of the ripple-carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/adder_core.sv
// Registered WIDTH-bit adder. It uses a ripple-carry chain of full-adder
// cells and reports unsigned carry-out and signed overflow one cycle after
// a qualified input.
module adder_core
  import adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  adder_core_if.slave bus
);

  // Reject widths the core is not meant to build.
  generate
    if (WIDTH < 1 || WIDTH > ADDER_MAX_WIDTH) begin : g_bad_width
      $error("adder_core: WIDTH out of range 1..64");
    end
  endgenerate

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;
  logic             ovf_comb;

  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             ovf_reg;
  logic             valid_reg;

  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      full_adder u_fa (
        .a    (bus.A[gi]),
        .b    (bus.B[gi]),
        .cin  (carry[gi]),
        .s    (sum_comb[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  assign ovf_comb = adder_overflow(bus.A[WIDTH-1], bus.B[WIDTH-1], sum_comb[WIDTH-1]);

  // Result registers load only on qualified input. The valid flag tracks in_valid every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        sum_reg   <= sum_comb;
        carry_reg <= carry[WIDTH];
        ovf_reg   <= ovf_comb;
      end
    end
  end

  assign bus.Sum       = sum_reg;
  assign bus.carry_out = carry_reg;
  assign bus.overflow  = ovf_reg;
  assign bus.out_valid = valid_reg;

endmodule

// File: tb/tb_adder_core.sv
// Directed testbench for adder_core at WIDTH=4 and WIDTH=8.
module tb_adder_core;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  adder_core_if #(.WIDTH(4)) if4 ();
  adder_core_if #(.WIDTH(8)) if8 ();

  adder_core #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  adder_core #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one WIDTH=4 operand pair, then sample just after the loading edge.
  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic v);
    @(negedge clk);
    if4.A        = a;
    if4.B        = b;
    if4.in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    if8.A        = a;
    if8.B        = b;
    if8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if8.in_valid = 1'b0;
  endtask

  task automatic chk4(input string tag, input logic [3:0] s, input logic c,
                      input logic o, input logic v);
    chk({tag, "_sum"}, 64'(if4.Sum), 64'(s));
    chk({tag, "_cout"}, 64'(if4.carry_out), 64'(c));
    chk({tag, "_ovf"}, 64'(if4.overflow), 64'(o));
    chk({tag, "_vld"}, 64'(if4.out_valid), 64'(v));
    $display("%t %s: Sum=%h cout=%b ovf=%b vld=%b", $time, tag,
             if4.Sum, if4.carry_out, if4.overflow, if4.out_valid);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst_n        = 1'b0;
    if4.in_valid = 1'b0;
    if4.A        = '0;
    if4.B        = '0;
    if8.in_valid = 1'b0;
    if8.A        = '0;
    if8.B        = '0;

    // Reset state before any clock edge.
    #2;
    chk4("reset", 4'h0, 1'b0, 1'b0, 1'b0);
    chk("reset8_sum", 64'(if8.Sum), 64'h0);
    chk("reset8_vld", 64'(if8.out_valid), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive sweep at WIDTH=4.
    for (int i = 0; i < 256; i++) begin
      int a;
      int b;
      int s;
      logic ov;
      a = i >> 4;
      b = i & 15;
      s = a + b;
      ov = (((a >> 3) & 1) == ((b >> 3) & 1)) && (((s >> 3) & 1) != ((a >> 3) & 1));
      drive4(4'(a), 4'(b), 1'b1);
      chk("sweep_sum", 64'(if4.Sum), 64'(s & 15));
      chk("sweep_cout", 64'(if4.carry_out), 64'((s >> 4) & 1));
      chk("sweep_ovf", 64'(if4.overflow), 64'(ov));
      chk("sweep_vld", 64'(if4.out_valid), 64'h1);
    end
    $display("%t sweep: 256 vectors done", $time);

    // Wrap-around and overflow corners.
    drive4(4'hF, 4'h1, 1'b1);
    chk4("wrap_f_1", 4'h0, 1'b1, 1'b0, 1'b1);
    drive4(4'h7, 4'h1, 1'b1);
    chk4("pos_ovf", 4'h8, 1'b0, 1'b1, 1'b1);
    drive4(4'h8, 4'h8, 1'b1);
    chk4("neg_ovf", 4'h0, 1'b1, 1'b1, 1'b1);
    drive4(4'hF, 4'hF, 1'b1);
    chk4("neg_noovf", 4'hE, 1'b1, 1'b0, 1'b1);

    // Valid gating: results hold while inputs change unqualified.
    drive4(4'h3, 4'h4, 1'b1);
    chk4("gate_load", 4'h7, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive4(4'h9, 4'h9, 1'b0);
      chk4("gate_idle", 4'h7, 1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset between edges.
    drive4(4'h4, 4'h6, 1'b1);
    chk4("pre_reset", 4'hA, 1'b0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk4("async_reset", 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n        = 1'b1;
    if4.A        = 4'h2;
    if4.B        = 4'h5;
    if4.in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk4("post_reset", 4'h7, 1'b0, 1'b0, 1'b1);
    if4.in_valid = 1'b0;

    // Width scaling at WIDTH=8.
    drive8(8'hFF, 8'h01);
    chk("w8_wrap_sum", 64'(if8.Sum), 64'h00);
    chk("w8_wrap_cout", 64'(if8.carry_out), 64'h1);
    chk("w8_wrap_vld", 64'(if8.out_valid), 64'h1);
    $display("%t w8_wrap: Sum=%h cout=%b", $time, if8.Sum, if8.carry_out);
    drive8(8'h40, 8'h40);
    chk("w8_ovf_sum", 64'(if8.Sum), 64'h80);
    chk("w8_ovf_ovf", 64'(if8.overflow), 64'h1);
    chk("w8_ovf_cout", 64'(if8.carry_out), 64'h0);
    $display("%t w8_ovf: Sum=%h ovf=%b", $time, if8.Sum, if8.overflow);
    @(posedge clk);
    #1;
    chk("w8_idle_vld", 64'(if8.out_valid), 64'h0);
    chk("w8_idle_sum", 64'(if8.Sum), 64'h80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
